// File: rtl/vector_dot.sv
// Sequential Q16.16 dot product of two 3-vectors sharing one signed 32x32 multiplier.
// Optional build macro VECTOR_DOT_SAT_EN saturates out-of-range results instead of wrapping.
module vector_dot (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_data,
    output logic        busy,
    output logic        output_valid,
    input  logic [95:0] v1,
    input  logic [95:0] v2,
    output logic [31:0] r
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MUL_X = 2'd1;
    localparam logic [1:0] MUL_Y = 2'd2;
    localparam logic [1:0] MUL_Z = 2'd3;

    logic [1:0]         state;
    logic [95:0]        op_a;
    logic [95:0]        op_b;
    logic signed [65:0] acc;

    logic signed [31:0] mul_a;
    logic signed [31:0] mul_b;
    logic signed [63:0] product;
    logic signed [65:0] acc_base;
    logic signed [65:0] sum;
    logic [31:0]        result;
    logic               unused_sum;

    // Single multiplier: operands selected by the current component state.
    always_comb begin
        mul_a = op_a[31:0];
        mul_b = op_b[31:0];
        case (state)
            MUL_Y: begin
                mul_a = op_a[63:32];
                mul_b = op_b[63:32];
            end
            MUL_Z: begin
                mul_a = op_a[95:64];
                mul_b = op_b[95:64];
            end
            default: begin
                mul_a = op_a[31:0];
                mul_b = op_b[31:0];
            end
        endcase
    end

    assign product  = mul_a * mul_b;
    assign acc_base = (state == MUL_X) ? '0 : acc;
    assign sum      = acc_base + {{2{product[63]}}, product};

`ifdef VECTOR_DOT_SAT_EN
    // Representable only when the bits above the result's sign bit are a pure sign extension.
    always_comb begin
        if ((&sum[65:47]) || !(|sum[65:47])) begin
            result = sum[47:16];
        end else if (sum[65]) begin
            result = 32'h8000_0000;
        end else begin
            result = 32'h7FFF_FFFF;
        end
    end
`else
    assign result = sum[47:16];
`endif

    assign unused_sum = ^{sum[65:48], sum[15:0]};
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            op_a         <= '0;
            op_b         <= '0;
            r            <= '0;
            output_valid <= 1'b0;
        end else begin
            output_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (new_data) begin
                        op_a  <= v1;
                        op_b  <= v2;
                        state <= MUL_X;
                    end
                end
                MUL_X: begin
                    acc   <= sum;
                    state <= MUL_Y;
                end
                MUL_Y: begin
                    acc   <= sum;
                    state <= MUL_Z;
                end
                MUL_Z: begin
                    r            <= result;
                    output_valid <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_dot.sv
// Directed and random checks of vector_dot against a plain-arithmetic dot-product model.
module tb_vector_dot;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_data;
    logic        busy;
    logic        output_valid;
    logic [95:0] v1;
    logic [95:0] v2;
    logic [31:0] r;

    int total = 0;
    int bad   = 0;

    vector_dot dut (
        .clk         (clk),
        .rst         (rst),
        .new_data    (new_data),
        .busy        (busy),
        .output_valid(output_valid),
        .v1          (v1),
        .v2          (v2),
        .r           (r)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] vec(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return {z, y, x};
    endfunction

    // Exact dot product, then floor-divide by 2^16 and fit into 32 bits.
    function automatic logic [31:0] dot_ref(input logic [95:0] a, input logic [95:0] b);
        logic signed [65:0] s;
        logic signed [65:0] lim;
        logic signed [31:0] x;
        logic signed [31:0] y;
        s   = '0;
        lim = 66'sd1 <<< 47;
        for (int i = 0; i < 3; i++) begin
            x = a[i*32 +: 32];
            y = b[i*32 +: 32];
            s = s + x * y;
        end
`ifdef VECTOR_DOT_SAT_EN
        if (s >= lim) return 32'h7FFF_FFFF;
        if (s < -lim) return 32'h8000_0000;
`endif
        s = s >>> 16;
        return s[31:0];
    endfunction

    function automatic logic [31:0] rnd_small();
        logic [31:0] u;
        u = $urandom();
        return {{10{u[21]}}, u[21:0]};
    endfunction

    // Issue one operation when idle and check the full 3-cycle busy / pulse timeline.
    task automatic do_op(input string tag, input logic [95:0] a, input logic [95:0] b,
                         input logic [31:0] expv);
        v1       = a;
        v2       = b;
        new_data = 1'b1;
        tick();
        new_data = 1'b0;
        v1       = {$urandom(), $urandom(), $urandom()};
        v2       = {$urandom(), $urandom(), $urandom()};
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_novalid"}, {31'd0, output_valid}, 32'd0);
        end
        tick();
        check({tag, "_valid"}, {31'd0, output_valid}, 32'd1);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_r"}, r, expv);
    endtask

    initial begin
        logic [95:0] a;
        logic [95:0] b;
        logic [95:0] set_a;
        logic [95:0] set_b;
        logic [31:0] sat_pos;

        rst      = 1'b1;
        new_data = 1'b0;
        v1       = '0;
        v2       = '0;
        tick();
        tick();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_valid", {31'd0, output_valid}, 32'd0);
        check("reset_r", r, 32'd0);

        // new_data together with rst must be ignored.
        v1       = vec(32'h0001_0000, 32'h0, 32'h0);
        v2       = vec(32'h0001_0000, 32'h0, 32'h0);
        new_data = 1'b1;
        tick();
        rst      = 1'b0;
        new_data = 1'b0;
        check("rst_newdata_busy", {31'd0, busy}, 32'd0);
        tick();
        check("rst_newdata_busy2", {31'd0, busy}, 32'd0);

        // Basic: (1,2,3).(4,5,6) = 32.0, result holds afterwards.
        a = vec(32'h0001_0000, 32'h0002_0000, 32'h0003_0000);
        b = vec(32'h0004_0000, 32'h0005_0000, 32'h0006_0000);
        do_op("basic", a, b, 32'h0020_0000);
        tick();
        check("basic_pulse_once", {31'd0, output_valid}, 32'd0);
        check("basic_hold", r, 32'h0020_0000);
        tick();
        check("basic_hold2", r, 32'h0020_0000);

        do_op("neg_frac", vec(32'hFFFE_8000, 32'h0, 32'h0), vec(32'h0002_0000, 32'h0, 32'h0),
              32'hFFFD_0000);
        do_op("floor", vec(32'hFFFF_FFFF, 32'h0, 32'h0), vec(32'h0000_0001, 32'h0, 32'h0),
              32'hFFFF_FFFF);
        do_op("tiny", vec(32'h0000_0001, 32'h0, 32'h0), vec(32'h0000_0001, 32'h0, 32'h0),
              32'h0000_0000);

`ifdef VECTOR_DOT_SAT_EN
        sat_pos = 32'h7FFF_FFFF;
`else
        sat_pos = 32'h0000_0000;
`endif
        do_op("overflow_pos", vec(32'h0100_0000, 32'h0, 32'h0),
              vec(32'h0100_0000, 32'h0, 32'h0), sat_pos);
        a = vec(32'hFF00_0000, 32'h0, 32'h0);
        b = vec(32'h0100_0000, 32'h0, 32'h0);
        do_op("overflow_neg", a, b, dot_ref(a, b));

        // Busy drop: second strobe one cycle later is lost.
        set_a = vec(32'h0003_0000, 32'hFFFF_0000, 32'h0000_8000);
        set_b = vec(32'h0002_0000, 32'h0004_0000, 32'h0006_0000);
        v1 = set_a;
        v2 = set_a;
        new_data = 1'b1;
        tick();
        v1 = set_b;
        v2 = set_b;
        tick();
        new_data = 1'b0;
        check("drop_busy", {31'd0, busy}, 32'd1);
        check("drop_novalid1", {31'd0, output_valid}, 32'd0);
        tick();
        check("drop_novalid2", {31'd0, output_valid}, 32'd0);
        tick();
        check("drop_valid", {31'd0, output_valid}, 32'd1);
        check("drop_r", r, dot_ref(set_a, set_a));
        do_op("drop_next", set_b, set_b, dot_ref(set_b, set_b));

        // Reset mid-operation aborts and clears r.
        v1 = set_a;
        v2 = set_b;
        new_data = 1'b1;
        tick();
        new_data = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, output_valid}, 32'd0);
        check("abort_r", r, 32'd0);
        do_op("after_abort", set_a, set_b, dot_ref(set_a, set_b));

        // Back-to-back random in-range operands.
        for (int n = 0; n < 100; n++) begin
            a = vec(rnd_small(), rnd_small(), rnd_small());
            b = vec(rnd_small(), rnd_small(), rnd_small());
            do_op("random", a, b, dot_ref(a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
